// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//
// Contents:
//   SEL_W            width of every register select
//   SEL_R0..SEL_IMM  select codes; 11..14 are unmapped
//   FLAG_N..FLAG_V   CPSR flag bit positions (N is the MSB)
//   sel_is_gpr()     true when a select addresses an implemented GPR
package regfile_pkg;

    localparam int unsigned SEL_W = 4;

    localparam logic [SEL_W-1:0] SEL_R0  = 4'd0;
    localparam logic [SEL_W-1:0] SEL_R1  = 4'd1;
    localparam logic [SEL_W-1:0] SEL_R2  = 4'd2;
    localparam logic [SEL_W-1:0] SEL_R3  = 4'd3;
    localparam logic [SEL_W-1:0] SEL_R4  = 4'd4;
    localparam logic [SEL_W-1:0] SEL_R5  = 4'd5;
    localparam logic [SEL_W-1:0] SEL_R6  = 4'd6;
    localparam logic [SEL_W-1:0] SEL_R7  = 4'd7;
    localparam logic [SEL_W-1:0] SEL_SP  = 4'd8;
    localparam logic [SEL_W-1:0] SEL_PC  = 4'd9;
    localparam logic [SEL_W-1:0] SEL_LR  = 4'd10;
    localparam logic [SEL_W-1:0] SEL_IMM = 4'd15;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // Codes 0..7 name GPRs, but only those below the configured count exist.
    function automatic logic sel_is_gpr(input logic [SEL_W-1:0] sel, input int unsigned num_gpr);
        return 32'(sel) < num_gpr;
    endfunction

endpackage

// File: rtl/regfile_read_mux.sv
// One read port of the register file: picks a register (or the immediate) by select.
//
// Optional feature (macro REGFILE_BYPASS_EN): when defined, a select matching an
// enabled same-cycle write to a GPR, SP or LR returns that write data, port A first.
// PC and IMM are never bypassed. When undefined, only registered state is returned.
//
// Ports:
//   sel                select code for this port
//   gpr                flattened GPR state, GPR i at [DATA_W*i +: DATA_W]
//   sp, pc, lr         special register state
//   imm                immediate pseudo-register value
//   wa_en/dest/data    write port A (used only for bypass)
//   wb_en/dest/data    write port B (used only for bypass)
//   data               selected read value
module regfile_read_mux
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_GPR = 8
) (
    input  logic [SEL_W-1:0]          sel,
    input  logic [NUM_GPR*DATA_W-1:0] gpr,
    input  logic [DATA_W-1:0]         sp,
    input  logic [DATA_W-1:0]         pc,
    input  logic [DATA_W-1:0]         lr,
    input  logic [DATA_W-1:0]         imm,
    input  logic                      wa_en,
    input  logic [SEL_W-1:0]          wa_dest,
    input  logic [DATA_W-1:0]         wa_data,
    input  logic                      wb_en,
    input  logic [SEL_W-1:0]          wb_dest,
    input  logic [DATA_W-1:0]         wb_data,
    output logic [DATA_W-1:0]         data
);

    logic [DATA_W-1:0] state_val;

    // Unimplemented GPRs and unmapped codes fall through to zero.
    always_comb begin
        state_val = '0;
        for (int i = 0; i < int'(NUM_GPR); i++) begin
            if (sel == SEL_W'(i)) begin
                state_val = gpr[i*DATA_W +: DATA_W];
            end
        end
        case (sel)
            SEL_SP:  state_val = sp;
            SEL_PC:  state_val = pc;
            SEL_LR:  state_val = lr;
            SEL_IMM: state_val = imm;
            default: ;
        endcase
    end

`ifdef REGFILE_BYPASS_EN
    logic bypass_ok;

    // sel == dest on a hit, so checking sel suffices to exclude PC/IMM/unmapped.
    assign bypass_ok = sel_is_gpr(sel, NUM_GPR) || (sel == SEL_SP) || (sel == SEL_LR);

    always_comb begin
        data = state_val;
        if (bypass_ok && wa_en && (wa_dest == sel)) begin
            data = wa_data;
        end else if (bypass_ok && wb_en && (wb_dest == sel)) begin
            data = wb_data;
        end
    end
`else
    logic unused_bypass;

    assign unused_bypass = ^{wa_en, wa_dest, wa_data, wb_en, wb_dest, wb_data};
    assign data          = state_val;
`endif

endmodule

// File: rtl/register_file_mp.sv
// Multi-port CPU register file: NUM_GPR general registers plus SP, PC, LR, CPSR and a
// read-only immediate pseudo-register.
//
// Optional feature (macro REGFILE_BYPASS_EN): same-cycle write-to-read bypass on the
// read ports for GPRs, SP and LR. Default build reads registered state only.
//
// Ports:
//   clk, rst_n         rising-edge clock, synchronous active-low reset
//   rd_sel/rd_data     NUM_RD combinational read ports, port i at slice i
//   wa_en/dest/data    write port A (ALU result); wins over B on a shared dest
//   wb_en/dest/data    write port B (load / base writeback)
//   immediate_in       value returned for select IMM
//   next_pc, pc_en     PC advance; an explicit PC write takes priority
//   cpsr_in, cpsr_we   per-flag CPSR update (bit3=N .. bit0=V)
//   pc_out, cpsr_out   current PC and flags
//
// Legal configuration: NUM_GPR in 1..8, NUM_RD in 1..4.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       NUM_GPR  = 8,
    parameter int unsigned       NUM_RD   = 2,
    parameter logic [DATA_W-1:0] RESET_PC = '0,
    parameter logic [DATA_W-1:0] RESET_SP = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SEL_W*NUM_RD-1:0]  rd_sel,
    output logic [DATA_W*NUM_RD-1:0] rd_data,
    input  logic                     wa_en,
    input  logic [SEL_W-1:0]         wa_dest,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     wb_en,
    input  logic [SEL_W-1:0]         wb_dest,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic [DATA_W-1:0]        immediate_in,
    input  logic [DATA_W-1:0]        next_pc,
    input  logic                     pc_en,
    input  logic [3:0]               cpsr_in,
    input  logic [3:0]               cpsr_we,
    output logic [DATA_W-1:0]        pc_out,
    output logic [3:0]               cpsr_out
);

    logic [DATA_W-1:0] gpr_q [NUM_GPR];
    logic [DATA_W-1:0] gpr_d [NUM_GPR];
    logic [DATA_W-1:0] sp_q, sp_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] lr_q, lr_d;
    logic [3:0]        cpsr_q, cpsr_d;

    logic [NUM_GPR*DATA_W-1:0] gpr_flat;

    // Next-state. Port B is applied before port A so that A overwrites B on a shared
    // dest. PC defaults to the pc_en advance, which either write then overrides.
    // Unimplemented GPR codes, unmapped codes and IMM match nothing and are dropped.
    always_comb begin
        gpr_d  = gpr_q;
        sp_d   = sp_q;
        lr_d   = lr_q;
        pc_d   = pc_en ? next_pc : pc_q;
        cpsr_d = (cpsr_we & cpsr_in) | (~cpsr_we & cpsr_q);

        if (wb_en) begin
            for (int i = 0; i < int'(NUM_GPR); i++) begin
                if (wb_dest == SEL_W'(i)) begin
                    gpr_d[i] = wb_data;
                end
            end
            case (wb_dest)
                SEL_SP:  sp_d = wb_data;
                SEL_PC:  pc_d = wb_data;
                SEL_LR:  lr_d = wb_data;
                default: ;
            endcase
        end

        if (wa_en) begin
            for (int i = 0; i < int'(NUM_GPR); i++) begin
                if (wa_dest == SEL_W'(i)) begin
                    gpr_d[i] = wa_data;
                end
            end
            case (wa_dest)
                SEL_SP:  sp_d = wa_data;
                SEL_PC:  pc_d = wa_data;
                SEL_LR:  lr_d = wa_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_GPR); i++) begin
                gpr_q[i] <= '0;
            end
            sp_q   <= RESET_SP;
            pc_q   <= RESET_PC;
            lr_q   <= '0;
            cpsr_q <= '0;
        end else begin
            gpr_q  <= gpr_d;
            sp_q   <= sp_d;
            pc_q   <= pc_d;
            lr_q   <= lr_d;
            cpsr_q <= cpsr_d;
        end
    end

    always_comb begin
        gpr_flat = '0;
        for (int i = 0; i < int'(NUM_GPR); i++) begin
            gpr_flat[i*DATA_W +: DATA_W] = gpr_q[i];
        end
    end

    for (genvar p = 0; p < int'(NUM_RD); p++) begin : gen_rd
        regfile_read_mux #(
            .DATA_W  (DATA_W),
            .NUM_GPR (NUM_GPR)
        ) u_read_mux (
            .sel     (rd_sel[p*SEL_W +: SEL_W]),
            .gpr     (gpr_flat),
            .sp      (sp_q),
            .pc      (pc_q),
            .lr      (lr_q),
            .imm     (immediate_in),
            .wa_en   (wa_en),
            .wa_dest (wa_dest),
            .wa_data (wa_data),
            .wb_en   (wb_en),
            .wb_dest (wb_dest),
            .wb_data (wb_data),
            .data    (rd_data[p*DATA_W +: DATA_W])
        );
    end

    assign pc_out   = pc_q;
    assign cpsr_out = cpsr_q;

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised successor of the CPU register file.
- Register set: NUM_GPR general registers, SP, PC, LR, CPSR, and a read-only immediate pseudo-register.
- NUM_RD combinational read ports and two synchronous write ports. Port A is the ALU result; port B is the load/base-writeback path.
- PC auto-advances from next_pc. CPSR is updated per flag under a write mask.
- Sits between decode (selects) and execute (operands) in the core datapath.

Parameters:
- DATA_W, 32, width of every register and data port.
- NUM_GPR, 8, number of general registers R0..R(NUM_GPR-1); legal range 1..8.
- NUM_RD, 2, number of read ports; legal range 1..4.
- RESET_PC, 32'h0, PC value after reset.
- RESET_SP, 32'h0, SP value after reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- rd_sel  in  4*NUM_RD  read selects; port i uses bits [4i+3:4i].
- rd_data  out  DATA_W*NUM_RD  read data; port i uses bits [DATA_W*i+DATA_W-1:DATA_W*i].
- wa_en  in  1  write enable, port A.
- wa_dest  in  4  destination select, port A.
- wa_data  in  DATA_W  write data, port A.
- wb_en  in  1  write enable, port B.
- wb_dest  in  4  destination select, port B.
- wb_data  in  DATA_W  write data, port B.
- immediate_in  in  DATA_W  value returned for select IMM.
- next_pc  in  DATA_W  PC value loaded when pc_en is high.
- pc_en  in  1  PC advance enable.
- cpsr_in  in  4  new N,Z,C,V flags (bit3=N … bit0=V).
- cpsr_we  in  4  per-flag write mask.
- pc_out  out  DATA_W  current PC.
- cpsr_out  out  4  current N,Z,C,V flags.

Behaviour:
- Select encoding:
  - 0..7: R0..R7. Codes at or above NUM_GPR read 0, and writes to them are dropped.
  - 8: SP. 9: PC. 10: LR. 15: IMM.
  - 11..14: unmapped; read 0, writes dropped.
- Reads are combinational from the register state (or bypass, see Optional Feature). IMM returns immediate_in.
- Reset: at a clk edge with rst_n=0:
  - All GPRs, LR and CPSR go to 0; SP goes to RESET_SP; PC goes to RESET_PC.
  - Reset overrides every write, pc_en and cpsr_we in that cycle.
  - After reset: pc_out=RESET_PC, cpsr_out=0, and rd_data reflects the reset register values.
- Writes take effect at the rising edge and are visible on reads in the following cycle.
- Writes with dest=IMM or an unmapped code are ignored.
- Simultaneous writes to the same dest: port A wins and port B is discarded. Different dests are both written.
- PC update priority, highest first:
  1. Explicit write to PC (port A over port B).
  2. pc_en=1 loads next_pc.
  3. Otherwise PC holds.
- CPSR: each flag bit k loads cpsr_in[k] iff cpsr_we[k]=1; the other bits hold.
- No internal state machine beyond the registers; latency is 1 cycle for writes and 0 for reads.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read port whose select matches an enabled same-cycle write returns that write data combinationally, with port A taking priority over port B.
  - Applies to GPRs, SP and LR.
  - PC and IMM are never bypassed.
  - Writes to unmapped codes or codes at or above NUM_GPR never bypass.
- Undefined: reads return only registered state, so a write is visible one cycle later.

Decomposition:
- Shared package regfile_pkg holds:
  - Select constants: SEL_R0..SEL_R7, SEL_SP, SEL_PC, SEL_LR, SEL_IMM.
  - SEL_W=4.
  - Flag bit indices: FLAG_N, FLAG_Z, FLAG_C, FLAG_V.
- One natural sub-module: regfile_read_mux, one per-port read/bypass selector, instantiated NUM_RD times through generate.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with RESET_PC=32'h100, RESET_SP=32'h8000, wa_en=1 -> pc_out=32'h100; reading SP gives 32'h8000; R0..R7 read 0; cpsr_out=0.
2. Dual write: wa R1=32'hA5A5_0001 and wb R2=32'h0000_0022 in the same cycle -> next cycle rd0(sel R1)=32'hA5A5_0001 and rd1(sel R2)=32'h22.
3. Write conflict: wa R3=32'h11 and wb R3=32'h22 -> R3 reads 32'h11. A write to IMM or to code 12 changes nothing, and IMM still reads immediate_in=32'h3.
4. PC priority: pc_en=1 with next_pc=32'h4 -> pc_out=4. pc_en=1 with next_pc=32'h8 while wa writes PC=32'h40 -> pc_out=32'h40. pc_en=0 -> PC holds.
5. CPSR mask: cpsr_in=4'b1111, cpsr_we=4'b1010 from 0 -> cpsr_out=4'b1010. Then cpsr_in=0, cpsr_we=4'b0010 -> cpsr_out=4'b1000.
6. Bypass: wa R5=32'hDEAD while rd0 selects R5 in the same cycle -> rd0=32'hDEAD when REGFILE_BYPASS_EN is defined, otherwise the old value 0. With NUM_GPR=4, a write to R6 is ignored and R6 reads 0.
